implied_vol_solver: RTL and testbench

- Inverse of the Black-Scholes pricing path: given a market option price, find the volatility sigma that reproduces it.
- Runs a bisection search on sigma. It drives an external pricer (the existing top-level pricing path) through a px_* port group and reads back the model price.
- Sits beside the pricer. Spot, strike, timetm, rate and otype are latched once per solve; only sigma changes between iterations.

---
 rtl/implied_vol_solver_if.sv | 33 +++
 rtl/implied_vol_solver.sv | 170 +++++++++++++++++
 tb/tb_implied_vol_solver.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/implied_vol_solver_if.sv
// Pricer port group: operands out to the Black-Scholes pricer,
// model price back from it.
interface implied_vol_solver_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] px_spot;
  logic [WIDTH-1:0] px_strike;
  logic [WIDTH-1:0] px_timetm;
  logic [WIDTH-1:0] px_rate;
  logic             px_otype;
  logic [WIDTH-1:0] px_sigma;
  logic [WIDTH-1:0] px_price;

  modport master (
    output px_spot,
    output px_strike,
    output px_timetm,
    output px_rate,
    output px_otype,
    output px_sigma,
    input  px_price
  );

  modport slave (
    input  px_spot,
    input  px_strike,
    input  px_timetm,
    input  px_rate,
    input  px_otype,
    input  px_sigma,
    output px_price
  );
endinterface

// File: rtl/implied_vol_solver.sv
// Implied volatility by bisection on sigma, driving an external
// fixed-latency pricer and comparing its price to the market target.
module implied_vol_solver #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SIG_MIN  = 32'h0000_0148,
  parameter logic [WIDTH-1:0] SIG_MAX  = 32'h0005_0000,
  parameter int               MAX_ITER = 24,
  parameter int               LATENCY  = 16,
  parameter logic [WIDTH-1:0] TOL      = 32'h0000_0010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     spot,
  input  logic [WIDTH-1:0]     strike,
  input  logic [WIDTH-1:0]     timetm,
  input  logic [WIDTH-1:0]     rate,
  input  logic                 otype,
  input  logic [WIDTH-1:0]     mkt_price,
  implied_vol_solver_if.master px,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     sigma_out,
  output logic                 converged,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_FINISH
  } state_t;

  localparam logic [7:0] LAT8  = 8'(LATENCY);
  localparam logic [7:0] ITER8 = 8'(MAX_ITER);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_spot;
  logic [WIDTH-1:0] r_strike;
  logic [WIDTH-1:0] r_timetm;
  logic [WIDTH-1:0] r_rate;
  logic             r_otype;
  logic [WIDTH-1:0] r_sigma;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_sigma_out;
  logic             r_conv;
  logic             r_err;
  logic             r_done;
  logic [7:0]       r_cnt;
  logic [7:0]       r_iter;

  logic [7:0]       w_iter_nxt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mid;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_abs;
  logic             w_hit;
  logic             w_pos;
  logic             w_last;
  logic             w_bad;

  // One extra bit keeps lo+hi and price-target free of overflow
  assign w_sum  = {r_lo[WIDTH-1], r_lo} + {r_hi[WIDTH-1], r_hi};
  assign w_mid  = WIDTH'($signed(w_sum) >>> 1);
  assign w_diff = {px.px_price[WIDTH-1], px.px_price}
                - {r_target[WIDTH-1], r_target};
  assign w_abs  = w_diff[WIDTH] ? -w_diff : w_diff;
  assign w_hit  = (w_abs <= {1'b0, TOL});
  assign w_pos  = !w_diff[WIDTH] && (w_diff != '0);
  assign w_bad  = mkt_price[WIDTH-1] || (mkt_price == '0);

  assign w_iter_nxt = r_iter + 8'd1;
  assign w_last     = (w_iter_nxt == ITER8);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_bad ? S_FINISH : S_ISSUE;
      end
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 8'd1) w_next = S_COMPARE;
      end
      S_COMPARE: w_next = (w_hit || w_last) ? S_FINISH : S_ISSUE;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spot      <= '0;
      r_strike    <= '0;
      r_timetm    <= '0;
      r_rate      <= '0;
      r_otype     <= 1'b0;
      r_sigma     <= SIG_MIN;
      r_target    <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_sigma_out <= '0;
      r_conv      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_iter      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spot   <= spot;
            r_strike <= strike;
            r_timetm <= timetm;
            r_rate   <= rate;
            r_otype  <= otype;
            r_target <= mkt_price;
            r_lo     <= SIG_MIN;
            r_hi     <= SIG_MAX;
            r_iter   <= '0;
            r_conv   <= 1'b0;
            r_err    <= w_bad;
          end
        end
        S_ISSUE: begin
          r_sigma <= w_mid;
          r_cnt   <= LAT8;
        end
        S_WAIT: r_cnt <= r_cnt - 8'd1;
        S_COMPARE: begin
          r_iter <= w_iter_nxt;
          if (w_hit)      r_conv <= 1'b1;
          else if (w_pos) r_hi   <= r_sigma;
          else            r_lo   <= r_sigma;
        end
        S_FINISH: begin
          r_sigma_out <= r_err ? SIG_MIN : r_sigma;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign px.px_spot   = r_spot;
  assign px.px_strike = r_strike;
  assign px.px_timetm = r_timetm;
  assign px.px_rate   = r_rate;
  assign px.px_otype  = r_otype;
  assign px.px_sigma  = r_sigma;

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign sigma_out = r_sigma_out;
  assign converged = r_conv;
  assign err       = r_err;

endmodule

// File: tb/tb_implied_vol_solver.sv
// Bench for implied_vol_solver: stub and real-arithmetic pricers,
// bisection reference model, timing and reset scenarios.
module tb_implied_vol_solver;
  localparam int          LAT      = 16;
  localparam int          MAX_ITER = 24;
  localparam logic [31:0] SIG_MIN  = 32'h0000_0148;
  localparam logic [31:0] SIG_MAX  = 32'h0005_0000;
  localparam logic [31:0] TOL      = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] spot;
  logic [31:0] strike;
  logic [31:0] timetm;
  logic [31:0] rate;
  logic        otype;
  logic [31:0] mkt_price;
  logic        busy;
  logic        done;
  logic [31:0] sigma_out;
  logic        converged;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit use_real = 1'b0;

  implied_vol_solver_if #(.WIDTH(32)) pxif ();

  implied_vol_solver dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spot      (spot),
    .strike    (strike),
    .timetm    (timetm),
    .rate      (rate),
    .otype     (otype),
    .mkt_price (mkt_price),
    .px        (pxif),
    .busy      (busy),
    .done      (done),
    .sigma_out (sigma_out),
    .converged (converged),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic real q2r(input logic [31:0] q);
    return $itor($signed(q)) / 65536.0;
  endfunction

  function automatic real ncdf(input real x);
    real ax, t, poly, n;
    ax = (x < 0.0) ? -x : x;
    t = 1.0 / (1.0 + 0.2316419 * ax);
    poly = t * (0.319381530 + t * (-0.356563782 + t * (1.781477937
         + t * (-1.821255978 + t * 1.330274429))));
    n = 1.0 - $exp(-ax * ax / 2.0) / $sqrt(2.0 * 3.14159265358979) * poly;
    return (x < 0.0) ? 1.0 - n : n;
  endfunction

  function automatic logic signed [31:0] price_fn(
    input bit rl, input logic [31:0] s, input logic [31:0] k,
    input logic [31:0] t, input logic [31:0] r, input logic ot,
    input logic [31:0] sg);
    real S, K, T, R, V, vol, d1, d2, df, c;
    if (!rl) return $signed(sg) * 32'sd20;
    S = q2r(s); K = q2r(k); T = q2r(t); R = q2r(r); V = q2r(sg);
    if (S <= 0.0 || K <= 0.0 || T <= 0.0 || V <= 0.0) return 32'sd0;
    vol = V * $sqrt(T);
    d1 = ($ln(S / K) + (R + V * V / 2.0) * T) / vol;
    d2 = d1 - vol;
    df = $exp(-R * T);
    if (ot) c = K * df * ncdf(-d2) - S * ncdf(-d1);
    else    c = S * ncdf(d1) - K * df * ncdf(d2);
    return $rtoi(c * 65536.0);
  endfunction

  // Pricer: price of the current operands appears LAT edges later
  logic signed [31:0] r_pipe [LAT];
  always @(posedge clk) begin
    r_pipe[0] <= price_fn(use_real, pxif.px_spot, pxif.px_strike,
                          pxif.px_timetm, pxif.px_rate, pxif.px_otype,
                          pxif.px_sigma);
    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign pxif.px_price = r_pipe[LAT-1];

  // Reference: plain bisection on sigma, straight from the algorithm
  task automatic model(
    input bit rl, input logic [31:0] s, input logic [31:0] k,
    input logic [31:0] t, input logic [31:0] r, input logic ot,
    input logic [31:0] tgt,
    output logic [31:0] sig, output bit conv, output int iters);
    longint lo, hi, mid, d;
    lo = longint'(SIG_MIN);
    hi = longint'(SIG_MAX);
    mid = lo;
    conv = 1'b0;
    iters = MAX_ITER;
    for (int i = 0; i < MAX_ITER && !conv; i++) begin
      mid = (lo + hi) / 2;
      d = longint'(price_fn(rl, s, k, t, r, ot, mid[31:0]))
        - longint'($signed(tgt));
      if (d <= longint'(TOL) && d >= -longint'(TOL)) begin
        conv = 1'b1;
        iters = i + 1;
      end else if (d > 0) hi = mid;
      else lo = mid;
    end
    sig = mid[31:0];
  endtask

  task automatic run_solve(
    input bit rl, input logic [31:0] s, input logic [31:0] k,
    input logic [31:0] t, input logic [31:0] r, input logic ot,
    input logic [31:0] mkt, input int inject,
    output int cyc, output bit busy1, output bit sig_stable);
    logic [31:0] sg0;
    use_real = rl;
    @(negedge clk);
    spot = s; strike = k; timetm = t; rate = r; otype = ot;
    mkt_price = mkt;
    start = 1'b1;
    sg0 = pxif.px_sigma;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    cyc = 1;
    sig_stable = 1'b1;
    while (!done && cyc < 3000) begin
      if (cyc == inject) begin
        start = 1'b1;
        spot = ~s;
        mkt_price = mkt + 32'h0001_0000;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (pxif.px_sigma !== sg0) sig_stable = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %0b want 0", done);
    end
    checks++;
    if (pxif.px_sigma !== SIG_MIN) begin
      errors++;
      $display("FAIL reset_px_sigma got %h want %h", pxif.px_sigma, SIG_MIN);
    end
    checks++;
    if (sigma_out !== 32'h0 || converged !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_results got %h/%0b/%0b want 0/0/0",
               sigma_out, converged, err);
    end
    checks++;
    if (pxif.px_spot !== 32'h0 || pxif.px_otype !== 1'b0) begin
      errors++;
      $display("FAIL reset_px_spot got %h want 0", pxif.px_spot);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_stub_basic;
    int cyc, it;
    bit b1, st, mc;
    logic [31:0] ms, s;
    longint e;
    s = 32'h0032_0000 + ($urandom & 32'hffff);
    model(1'b0, s, 32'h0064_0000, 32'h0001_0000, 32'd3277, 1'b0,
          32'h0004_0000, ms, mc, it);
    run_solve(1'b0, s, 32'h0064_0000, 32'h0001_0000, 32'd3277, 1'b0,
              32'h0004_0000, 0, cyc, b1, st);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stub_done got %0b want 1 (timeout)", done);
    end
    checks++;
    if (b1 !== 1'b1) begin
      errors++; $display("FAIL stub_busy got %0b want 1", b1);
    end
    checks++;
    if (cyc != 2 + it * (LAT + 2)) begin
      errors++;
      $display("FAIL stub_cycles got %0d want %0d", cyc, 2 + it * (LAT + 2));
    end
    checks++;
    if (converged !== 1'b1 || !mc) begin
      errors++;
      $display("FAIL stub_conv got %0b want 1", converged);
    end
    checks++;
    if (sigma_out !== ms) begin
      errors++; $display("FAIL stub_sigma got %h want %h", sigma_out, ms);
    end
    e = longint'(sigma_out) * 20 - 262144;
    checks++;
    if (e > 16 || e < -16) begin
      errors++;
      $display("FAIL stub_sigma_tol got %h want ~0x3333", sigma_out);
    end
    checks++;
    if (pxif.px_spot !== s || err !== 1'b0) begin
      errors++;
      $display("FAIL stub_latch got %h want %h", pxif.px_spot, s);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL stub_done_pulse got %0b want 0", done);
    end
  endtask

  task automatic test_unreachable;
    int cyc, it;
    bit b1, st, mc;
    logic [31:0] ms;
    model(1'b0, 32'h1, 32'h1, 32'h1, 32'h0, 1'b0, 32'h00C8_0000,
          ms, mc, it);
    run_solve(1'b0, 32'h1, 32'h1, 32'h1, 32'h0, 1'b0, 32'h00C8_0000,
              0, cyc, b1, st);
    checks++;
    if (done !== 1'b1 || cyc != 2 + MAX_ITER * (LAT + 2)) begin
      errors++;
      $display("FAIL unreach_cycles got %0d want %0d", cyc,
               2 + MAX_ITER * (LAT + 2));
    end
    checks++;
    if (converged !== 1'b0) begin
      errors++; $display("FAIL unreach_conv got %0b want 0", converged);
    end
    checks++;
    if (sigma_out !== ms || sigma_out < SIG_MAX - 32'd1) begin
      errors++;
      $display("FAIL unreach_sigma got %h want %h", sigma_out, ms);
    end
  endtask

  task automatic test_err;
    int cyc;
    bit b1, st;
    logic [31:0] m;
    for (int n = 0; n < 2; n++) begin
      m = (n == 0) ? 32'h0 : (32'h8000_0000 | $urandom);
      run_solve(1'b0, 32'h0064_0000, 32'h0064_0000, 32'h0001_0000,
                32'd3277, 1'b1, m, 0, cyc, b1, st);
      checks++;
      if (done !== 1'b1 || cyc != 2) begin
        errors++; $display("FAIL err_cycles got %0d want 2", cyc);
      end
      checks++;
      if (err !== 1'b1 || converged !== 1'b0) begin
        errors++;
        $display("FAIL err_flag got %0b/%0b want 1/0", err, converged);
      end
      checks++;
      if (sigma_out !== SIG_MIN) begin
        errors++;
        $display("FAIL err_sigma got %h want %h", sigma_out, SIG_MIN);
      end
      checks++;
      if (!st) begin
        errors++; $display("FAIL err_px_sigma got toggle want stable");
      end
    end
  endtask

  task automatic test_random;
    int cyc, it;
    bit b1, st, mc;
    logic [31:0] ms, s, k, t, r, m;
    logic ot;
    for (int n = 0; n < 6; n++) begin
      s = $urandom; k = $urandom; t = $urandom; r = $urandom;
      ot = 1'($urandom);
      m = $urandom_range(3277, 6488064);
      model(1'b0, s, k, t, r, ot, m, ms, mc, it);
      run_solve(1'b0, s, k, t, r, ot, m, 0, cyc, b1, st);
      checks++;
      if (done !== 1'b1 || cyc != 2 + it * (LAT + 2)) begin
        errors++;
        $display("FAIL rand_cycles got %0d want %0d", cyc,
                 2 + it * (LAT + 2));
      end
      checks++;
      if (sigma_out !== ms || converged !== mc || err !== 1'b0) begin
        errors++;
        $display("FAIL rand_result got %h/%0b want %h/%0b",
                 sigma_out, converged, ms, mc);
      end
      checks++;
      if (pxif.px_spot !== s || pxif.px_strike !== k ||
          pxif.px_timetm !== t || pxif.px_rate !== r ||
          pxif.px_otype !== ot) begin
        errors++;
        $display("FAIL rand_px got %h want %h", pxif.px_spot, s);
      end
    end
  endtask

  task automatic test_real(input logic ot, input logic [31:0] m);
    int cyc, it;
    bit b1, st, mc;
    logic [31:0] ms;
    longint e;
    model(1'b1, 32'h0064_0000, 32'h0064_0000, 32'h0001_0000, 32'd3277,
          ot, m, ms, mc, it);
    run_solve(1'b1, 32'h0064_0000, 32'h0064_0000, 32'h0001_0000,
              32'd3277, ot, m, 0, cyc, b1, st);
    checks++;
    if (done !== 1'b1 || cyc != 2 + it * (LAT + 2)) begin
      errors++;
      $display("FAIL real%0b_cycles got %0d want %0d", ot, cyc,
               2 + it * (LAT + 2));
    end
    e = longint'(sigma_out) - 13107;
    checks++;
    if (e > 131 || e < -131) begin
      errors++;
      $display("FAIL real%0b_sigma got %h want ~0x3333", ot, sigma_out);
    end
    checks++;
    if (sigma_out !== ms || converged !== mc) begin
      errors++;
      $display("FAIL real%0b_model got %h/%0b want %h/%0b", ot,
               sigma_out, converged, ms, mc);
    end
    checks++;
    if (pxif.px_otype !== ot) begin
      errors++;
      $display("FAIL real_otype got %0b want %0b", pxif.px_otype, ot);
    end
  endtask

  task automatic test_reset_midsolve;
    bit seen;
    use_real = 1'b0;
    @(negedge clk);
    spot = 32'h0011_0000; mkt_price = 32'h0004_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (78) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pxif.px_sigma !== SIG_MIN) begin
      errors++;
      $display("FAIL midreset_state got busy %0b sigma %h want 0 %h",
               busy, pxif.px_sigma, SIG_MIN);
    end
    checks++;
    if (pxif.px_spot !== 32'h0) begin
      errors++;
      $display("FAIL midreset_px_spot got %h want 0", pxif.px_spot);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midreset_no_done got pulse want none");
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, it;
    bit b1, st, mc;
    logic [31:0] ms, s, m;
    s = $urandom;
    m = $urandom_range(65536, 3276800);
    model(1'b0, s, 32'h0, 32'h0, 32'h0, 1'b0, m, ms, mc, it);
    run_solve(1'b0, s, 32'h0, 32'h0, 32'h0, 1'b0, m, 10, cyc, b1, st);
    checks++;
    if (done !== 1'b1 || cyc != 2 + it * (LAT + 2)) begin
      errors++;
      $display("FAIL busy_cycles got %0d want %0d", cyc, 2 + it * (LAT + 2));
    end
    checks++;
    if (pxif.px_spot !== s) begin
      errors++;
      $display("FAIL busy_px_spot got %h want %h", pxif.px_spot, s);
    end
    checks++;
    if (sigma_out !== ms || converged !== mc) begin
      errors++;
      $display("FAIL busy_result got %h/%0b want %h/%0b",
               sigma_out, converged, ms, mc);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    spot = '0; strike = '0; timetm = '0; rate = '0;
    otype = 1'b0; mkt_price = '0;
    test_reset();
    test_stub_basic();
    test_unreachable();
    test_err();
    test_random();
    test_real(1'b0, 32'd684889);
    test_real(1'b1, 32'd365265);
    test_reset_midsolve();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
